// File: rtl/matrix_memory_if.sv
// Request/response bundle between the CISC controller (master) and the
// matrix memory (slave). Signal names follow the controller's naming.
interface matrix_memory_if #(
  parameter int DATA_W = 256,
  parameter int ELEM_W = 16,
  parameter int ADDR_W = 8
);
  localparam int LANES = DATA_W / ELEM_W;

  logic              MemEnable;
  logic              MemReadWrite;   // 1 = read, 0 = write
  logic [ADDR_W-1:0] Address;
  logic [DATA_W-1:0] DataIn;
  logic [LANES-1:0]  ElemMask;
  logic [DATA_W-1:0] DataOut;
  logic              WriteDone;
  logic              AddrError;
  logic              Busy;

  modport master (
    output MemEnable, MemReadWrite, Address, DataIn, ElemMask,
    input  DataOut, WriteDone, AddrError, Busy
  );

  modport slave (
    input  MemEnable, MemReadWrite, Address, DataIn, ElemMask,
    output DataOut, WriteDone, AddrError, Busy
  );
endinterface

// File: rtl/matrix_memory.sv
// Matrix word store: DEPTH words of packed ELEM_W-bit elements, words 0/1
// preloaded with the ALU operand matrices. One access per four-phase
// enable/done handshake, with per-element write mask and range flag.
// DATA_W must be an integer multiple of ELEM_W.
module matrix_memory #(
  parameter int                DATA_W   = 256,
  parameter int                ELEM_W   = 16,
  parameter int                DEPTH    = 8,
  parameter int                ADDR_W   = 8,
  parameter logic [DATA_W-1:0] PRELOAD0 = 256'h0003_0010_000f_0002_000d_0008_0002_0009_0009_000b_0006_0007_0022_0004_000c_0004,
  parameter logic [DATA_W-1:0] PRELOAD1 = 256'h0009_0007_0005_0003_000c_000d_0038_0012_0001_0004_0006_0007_0016_0043_002d_0017
) (
  input  logic            clk,
  input  logic            reset,     // asynchronous, active low
  matrix_memory_if.slave  bus
);

  localparam int              LANES   = DATA_W / ELEM_W;
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACK      = 2'd1,
    WAIT_LOW = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              in_range;
  logic              mem_we;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] wr_word;

  // Extra MSB keeps the compare correct when DEPTH == 2**ADDR_W.
  assign in_range = ({1'b0, bus.Address} < DEPTH_W);

  // Read mux; an out-of-range address selects nothing and reads as zero.
  always_comb begin
    rd_word = '0;
    for (int w = 0; w < DEPTH; w++) begin
      if (bus.Address == ADDR_W'(w)) rd_word = mem_q[w];
    end
  end

  // Merge masked input lanes over the current word contents.
  always_comb begin
    wr_word = rd_word;
    for (int l = 0; l < LANES; l++) begin
      if (bus.ElemMask[l]) wr_word[l*ELEM_W +: ELEM_W] = bus.DataIn[l*ELEM_W +: ELEM_W];
    end
  end

  // Handshake FSM: next state, access decode and acknowledge outputs.
  // NOTE: every signal gets a hold/default value up front so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    dout_d  = dout_q;
    done_d  = done_q;
    err_d   = err_q;
    mem_we  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.MemEnable) begin
          state_d = ACK;
          done_d  = 1'b1;
          err_d   = !in_range;
          if (in_range) begin
            if (bus.MemReadWrite) dout_d = rd_word;
            else                  mem_we = 1'b1;
          end
        end
      end
      ACK: begin
        if (bus.MemEnable) begin
          state_d = WAIT_LOW;
        end else begin
          state_d = IDLE;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      WAIT_LOW: begin
        if (!bus.MemEnable) begin
          state_d = IDLE;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        done_d  = 1'b0;
        err_d   = 1'b0;
      end
    endcase
  end

  // Control and output registers.
  // NOTE: sequential state uses non-blocking assignment so all flops update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      dout_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Storage array with operand preload.
  // NOTE: the array is reset on purpose: words 0/1 must come up holding the operands
  // and the rest must read as zero, so it is built from resettable flops, not a RAM macro.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int w = 0; w < DEPTH; w++) begin
        mem_q[w] <= (w == 0) ? PRELOAD0 : (w == 1) ? PRELOAD1 : '0;
      end
    end else if (mem_we) begin
      for (int w = 0; w < DEPTH; w++) begin
        if (bus.Address == ADDR_W'(w)) mem_q[w] <= wr_word;
      end
    end
  end

  assign bus.DataOut   = dout_q;
  assign bus.WriteDone = done_q;
  assign bus.AddrError = err_q;
  assign bus.Busy      = (state_q != IDLE);

endmodule

// File: tb/tb_matrix_memory.sv
// Self-checking bench for matrix_memory (DEPTH reduced to 6 so that the
// out-of-range path is reachable with small addresses).
module tb_matrix_memory;

  localparam int DATA_W = 256;
  localparam int ELEM_W = 16;
  localparam int LANES  = DATA_W / ELEM_W;
  localparam int DEPTH  = 6;
  localparam int ADDR_W = 8;
  localparam logic [DATA_W-1:0] P0 = 256'h0003_0010_000f_0002_000d_0008_0002_0009_0009_000b_0006_0007_0022_0004_000c_0004;
  localparam logic [DATA_W-1:0] P1 = 256'h0009_0007_0005_0003_000c_000d_0038_0012_0001_0004_0006_0007_0016_0043_002d_0017;

  logic clk = 1'b0;
  logic reset;

  matrix_memory_if #(.DATA_W(DATA_W), .ELEM_W(ELEM_W), .ADDR_W(ADDR_W)) bus ();

  matrix_memory #(
    .DATA_W(DATA_W), .ELEM_W(ELEM_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
    .PRELOAD0(P0), .PRELOAD1(P1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Behavioural model: word array plus expected visible outputs.
  logic [DATA_W-1:0] model_mem [DEPTH];
  logic [DATA_W-1:0] exp_dout;
  logic              exp_done, exp_err, exp_busy;
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic model_reset();
    for (int w = 0; w < DEPTH; w++) model_mem[w] = (w == 0) ? P0 : (w == 1) ? P1 : '0;
    exp_dout = '0;
    exp_done = 1'b0;
    exp_err  = 1'b0;
    exp_busy = 1'b0;
  endtask

  function automatic logic [ELEM_W-1:0] lane(input logic [DATA_W-1:0] w, input int i);
    return w[i*ELEM_W +: ELEM_W];
  endfunction

  // Compare process: outputs are checked at every falling edge.
  always @(negedge clk) begin
    check("DataOut",   bus.DataOut,            exp_dout);
    check("WriteDone", DATA_W'(bus.WriteDone), DATA_W'(exp_done));
    check("AddrError", DATA_W'(bus.AddrError), DATA_W'(exp_err));
    check("Busy",      DATA_W'(bus.Busy),      DATA_W'(exp_busy));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full handshake starting from IDLE, aligned at posedge+1.
  // With hold>0 the enable stays high and the request fields are scrambled.
  task automatic access(input logic rd, input int addr, input logic [DATA_W-1:0] data,
                        input logic [LANES-1:0] mask, input int hold);
    bus.MemEnable    = 1'b1;
    bus.MemReadWrite = rd;
    bus.Address      = ADDR_W'(addr);
    bus.DataIn       = data;
    bus.ElemMask     = mask;
    step();
    exp_done = 1'b1;
    exp_busy = 1'b1;
    exp_err  = (addr >= DEPTH);
    if (addr < DEPTH) begin
      if (rd) exp_dout = model_mem[addr];
      else
        for (int i = 0; i < LANES; i++)
          if (mask[i]) model_mem[addr][i*ELEM_W +: ELEM_W] = data[i*ELEM_W +: ELEM_W];
    end
    for (int c = 0; c < hold; c++) begin
      bus.MemReadWrite = 1'b0;
      bus.Address      = ADDR_W'((addr + 1 + c) % DEPTH);
      bus.DataIn       = ~data;
      bus.ElemMask     = '1;
      step();
    end
    bus.MemEnable = 1'b0;
    step();
    exp_done = 1'b0;
    exp_err  = 1'b0;
    exp_busy = 1'b0;
  endtask

  task automatic read_all();
    for (int w = 0; w < DEPTH; w++) access(1'b1, w, '0, '0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.MemEnable    = 1'b0;
    bus.MemReadWrite = 1'b1;
    bus.Address      = '0;
    bus.DataIn       = '0;
    bus.ElemMask     = '0;
    model_reset();
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    check("rst_DataOut",   bus.DataOut, '0);
    check("rst_WriteDone", DATA_W'(bus.WriteDone), '0);
    check("rst_Busy",      DATA_W'(bus.Busy), '0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    step();

    // Preload reads, pinned with hand-computed lanes.
    access(1'b1, 0, '0, '0, 0);
    check("p0_lane0",  DATA_W'(lane(bus.DataOut, 0)),  DATA_W'(16'h0004));
    check("p0_lane15", DATA_W'(lane(bus.DataOut, 15)), DATA_W'(16'h0003));
    access(1'b1, 1, '0, '0, 0);
    check("p1_lane0",  DATA_W'(lane(bus.DataOut, 0)),  DATA_W'(16'h0017));
    check("p1_lane15", DATA_W'(lane(bus.DataOut, 15)), DATA_W'(16'h0009));
    access(1'b1, 5, '0, '0, 0);
    check("w5_zero", bus.DataOut, '0);

    // Masked write: lower eight lanes only; DataOut must stay at word 5's value.
    access(1'b0, 3, {LANES{16'hAAAA}}, 16'h00FF, 0);
    check("wr_keeps_dout", bus.DataOut, '0);
    access(1'b1, 3, '0, '0, 0);
    check("m_lane0",  DATA_W'(lane(bus.DataOut, 0)),  DATA_W'(16'hAAAA));
    check("m_lane7",  DATA_W'(lane(bus.DataOut, 7)),  DATA_W'(16'hAAAA));
    check("m_lane8",  DATA_W'(lane(bus.DataOut, 8)),  DATA_W'(16'h0000));
    check("m_lane15", DATA_W'(lane(bus.DataOut, 15)), DATA_W'(16'h0000));

    // Sparse mask over a patterned word.
    access(1'b0, 4, 256'h0123_4567_89ab_cdef_fedc_ba98_7654_3210_1111_2222_3333_4444_5555_6666_7777_8888,
           16'hA5A5, 0);
    access(1'b1, 4, '0, '0, 0);
    check("sp_lane0", DATA_W'(lane(bus.DataOut, 0)), DATA_W'(16'h8888));
    check("sp_lane1", DATA_W'(lane(bus.DataOut, 1)), DATA_W'(16'h0000));

    // Long hold with scrambled request fields: no second access may happen.
    access(1'b1, 2, {LANES{16'h5555}}, '0, 5);
    read_all();

    // Out-of-range read and write.
    access(1'b1, 7, '0, '0, 0);
    access(1'b0, 6, {LANES{16'hFFFF}}, '1, 0);
    read_all();

    // Write word 0, then reset during ACK.
    bus.MemEnable    = 1'b1;
    bus.MemReadWrite = 1'b0;
    bus.Address      = '0;
    bus.DataIn       = {LANES{16'h1234}};
    bus.ElemMask     = '1;
    step();
    check("pre_rst_done", DATA_W'(bus.WriteDone), DATA_W'(1'b1));
    bus.MemEnable = 1'b0;
    reset = 1'b0;
    model_reset();
    #1;
    check("abort_done", DATA_W'(bus.WriteDone), '0);
    check("abort_busy", DATA_W'(bus.Busy), '0);
    @(posedge clk);
    #3 reset = 1'b1;
    step();
    access(1'b1, 0, '0, '0, 0);
    check("after_rst_w0", bus.DataOut, P0);

    // All-zero mask write is acknowledged and changes nothing.
    access(1'b0, 1, {LANES{16'hBEEF}}, '0, 0);
    access(1'b1, 1, '0, '0, 0);
    check("zmask_w1", bus.DataOut, P1);

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
